// File: rtl/ring_edge_counter_if.sv
// Control/result bundle for ring_edge_counter.
// The master side (software or test harness) launches and aborts measurements.
// The slave side (the counter) reports the count and its status flags.
interface ring_edge_counter_if #(
  parameter int unsigned COUNT_W  = 32,
  parameter int unsigned WINDOW_W = 32
);

  logic                start;
  logic                stop;
  logic [WINDOW_W-1:0] window;
  logic [COUNT_W-1:0]  count;
  logic                busy;
  logic                done;
  logic                overflow;

  modport master (
    output start,
    output stop,
    output window,
    input  count,
    input  busy,
    input  done,
    input  overflow
  );

  modport slave (
    input  start,
    input  stop,
    input  window,
    output count,
    output busy,
    output done,
    output overflow
  );

endinterface

// File: rtl/ring_edge_counter.sv
// Ring oscillator edge counter.
//
// ring_in is asynchronous to wb_clk_i. It passes through a 2-flop synchroniser
// (s1, s2) and then an edge register (s3). Edges are counted over a gate window
// of a programmable number of clock cycles, so software can derive the ring
// frequency from the final count.
//
// Build option: define RING_COUNT_BOTH_EDGES_EN to count both ring edges
// (s2 ^ s3) instead of rising edges only (s2 & ~s3).
//
// Measurement flow: IDLE/DONE --start--> ARM (2 cycles) --> COUNT (window cycles) --> DONE.
// stop in ARM or COUNT aborts to IDLE and holds the partial count.
module ring_edge_counter #(
  parameter int unsigned COUNT_W  = 32,
  parameter int unsigned WINDOW_W = 32
) (
  input  logic               wb_clk_i,
  input  logic               rst_n,
  input  logic               ring_in,
  ring_edge_counter_if.slave ctrl
);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCount,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                s3_q, s3_d;
  logic                arm_q, arm_d;
  logic [WINDOW_W-1:0] win_q, win_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                edge_det;
  logic                count_full;

  // Edge detect on the synchronised ring signal
`ifdef RING_COUNT_BOTH_EDGES_EN
  assign edge_det = s2_q ^ s3_q;
`else
  assign edge_det = s2_q & ~s3_q;
`endif

  assign count_full = &count_q;

  // Next-state logic for the synchroniser, FSM and registered outputs
  always_comb begin
    s1_d    = ring_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    state_d = state_q;
    arm_d   = arm_q;
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      // stop is ignored here; start always launches
      StIdle, StDone: begin
        if (ctrl.start) begin
          state_d = StArm;
          arm_d   = 1'b0;
          win_d   = ctrl.window;
          count_d = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      // Two cycles with no counting so edges already in the synchroniser at
      // launch are discarded.
      StArm: begin
        if (ctrl.stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (!arm_q) begin
          arm_d = 1'b1;
        end else if (win_q == '0) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = StCount;
        end
      end

      // stop beats window expiry; the abort cycle itself is not counted
      StCount: begin
        if (ctrl.stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          if (edge_det) begin
            if (count_full) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + COUNT_W'(1);
            end
          end
          win_d = win_q - WINDOW_W'(1);
          if (win_q == WINDOW_W'(1)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears every output at once
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      arm_q   <= 1'b0;
      win_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      arm_q   <= arm_d;
      win_q   <= win_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ctrl.count    = count_q;
  assign ctrl.busy     = busy_q;
  assign ctrl.done     = done_q;
  assign ctrl.overflow = ovf_q;

endmodule

// File: tb/tb_ring_edge_counter.sv
// Bench for ring_edge_counter: a table of gated measurements plus hand-written
// abort, reset, saturation and re-launch sequences. The ring is a bench-driven
// square wave of period 8 clocks (or held constant).
module tb_ring_edge_counter;

`ifdef RING_COUNT_BOTH_EDGES_EN
  localparam bit BothEdges = 1'b1;
`else
  localparam bit BothEdges = 1'b0;
`endif

  localparam int RingToggle = 0;
  localparam int RingHigh   = 1;
  localparam int RingLow    = 2;

  typedef struct {
    logic [31:0] count;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    int unsigned win;
    int          mode;
    int unsigned exp_rise;
    int unsigned exp_both;
    bit          with_stop;
  } vec_t;

  logic clk;
  logic rst_n;
  logic ring_in;
  int   ring_ph;
  int   ring_mode;

  int   vectors;
  int   errors;
  exp_t sb_q[$];
  vec_t vecs[6];

  ring_edge_counter_if #(.COUNT_W(32), .WINDOW_W(32)) bus ();
  ring_edge_counter_if #(.COUNT_W(4), .WINDOW_W(32)) bus_s ();

  ring_edge_counter #(.COUNT_W(32), .WINDOW_W(32)) u_dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .ring_in  (ring_in),
    .ctrl     (bus)
  );

  ring_edge_counter #(.COUNT_W(4), .WINDOW_W(32)) u_dut_s (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .ring_in  (ring_in),
    .ctrl     (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_ring();
    logic [31:0] ph;
    ph = ring_ph;
    case (ring_mode)
      RingHigh: ring_in = 1'b1;
      RingLow:  ring_in = 1'b0;
      default:  ring_in = ph[2];
    endcase
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    ring_ph++;
    apply_ring();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [63:0] act,
                             input logic [63:0] lo, input logic [63:0] hi);
    vectors++;
    if ((^act === 1'bx) || act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] pick(input int unsigned r, input int unsigned b);
    return BothEdges ? b : r;
  endfunction

  // Wait for done on the main DUT and compare against the scoreboard head
  task automatic finish_main(input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    bit   busy_bad;
    lat      = 0;
    seen     = 1'b0;
    busy_bad = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (!bus.busy) busy_bad = 1'b1;
        tick();
        lat++;
      end
    end
    e = sb_q.pop_front();
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: done never rose, expected after %0d cycles", tag, e.lat);
      return;
    end
    check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    check({tag, "_busy_gap"}, {63'd0, busy_bad}, 64'd0);
    check({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_count"}, {32'd0, bus.count}, {32'd0, e.count});
    check({tag, "_overflow"}, {63'd0, bus.overflow}, {63'd0, e.ovf});
  endtask

  // Launch on the main DUT, scramble window after launch, then finish
  task automatic run_main(input int unsigned win, input int mode, input logic [31:0] exp_cnt,
                          input bit also_stop, input string tag);
    exp_t e;
    e.count = exp_cnt;
    e.ovf   = 1'b0;
    e.lat   = int'(win) + 2;
    bus.start  = 1'b1;
    bus.stop   = also_stop;
    bus.window = win;
    ring_mode  = mode;
    apply_ring();
    sb_q.push_back(e);
    tick();
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.window = $urandom();
    check({tag, "_busy_arm"}, {63'd0, bus.busy}, 64'd1);
    check({tag, "_count_cleared"}, {32'd0, bus.count}, 64'd0);
    finish_main(tag);
  endtask

  initial begin
    logic [31:0] cnt_hold;
    bit          flag;

    vecs[0] = '{win: 16, mode: RingToggle, exp_rise: 2, exp_both: 4,  with_stop: 1'b1};
    vecs[1] = '{win: 64, mode: RingToggle, exp_rise: 8, exp_both: 16, with_stop: 1'b0};
    vecs[2] = '{win: 0,  mode: RingToggle, exp_rise: 0, exp_both: 0,  with_stop: 1'b0};
    vecs[3] = '{win: 32, mode: RingHigh,   exp_rise: 0, exp_both: 0,  with_stop: 1'b0};
    vecs[4] = '{win: 32, mode: RingLow,    exp_rise: 0, exp_both: 0,  with_stop: 1'b0};
    vecs[5] = '{win: 40, mode: RingToggle, exp_rise: 5, exp_both: 10, with_stop: 1'b0};

    vectors      = 0;
    errors       = 0;
    ring_ph      = 0;
    ring_mode    = RingToggle;
    ring_in      = 1'b0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.window   = '0;
    bus_s.start  = 1'b0;
    bus_s.stop   = 1'b0;
    bus_s.window = '0;

    repeat (3) tick();
    check("reset_count", {32'd0, bus.count}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_overflow", {63'd0, bus.overflow}, 64'd0);
    rst_n = 1'b1;
    repeat (10) tick();

    // Table of measurements; first vector also has stop with start in IDLE
    for (int v = 0; v < 6; v++) begin
      run_main(vecs[v].win, vecs[v].mode, pick(vecs[v].exp_rise, vecs[v].exp_both),
               vecs[v].with_stop, $sformatf("vec%0d", v));
      ring_mode = RingToggle;
      repeat (8) tick();
    end

    // Abort 19 counted cycles into COUNT; a start pulse mid-COUNT must be ignored
    bus.start  = 1'b1;
    bus.window = 64;
    tick();
    bus.start  = 1'b0;
    bus.window = $urandom();
    repeat (2) tick();
    flag = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      if (c == 10) begin
        bus.start  = 1'b1;
        bus.window = 4;
      end
      tick();
      bus.start  = 1'b0;
      bus.window = $urandom();
      if (!bus.busy || bus.done) flag = 1'b1;
    end
    check("stop_no_relaunch", {63'd0, flag}, 64'd0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_busy", {63'd0, bus.busy}, 64'd0);
    check("stop_done", {63'd0, bus.done}, 64'd0);
    check_range("stop_partial", {32'd0, bus.count}, BothEdges ? 64'd3 : 64'd1,
                BothEdges ? 64'd6 : 64'd3);
    cnt_hold = bus.count;
    repeat (5) tick();
    check("stop_held", {32'd0, bus.count}, {32'd0, cnt_hold});
    check("stop_idle_done", {63'd0, bus.done}, 64'd0);

    // Asynchronous reset mid-COUNT, then a clean launch
    bus.start  = 1'b1;
    bus.window = 64;
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", {32'd0, bus.count}, 64'd0);
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_done", {63'd0, bus.done}, 64'd0);
    check("arst_overflow", {63'd0, bus.overflow}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("arst_idle_busy", {63'd0, bus.busy}, 64'd0);
    run_main(64, RingToggle, pick(8, 16), 1'b0, "post_rst");

    // stop in DONE is ignored
    cnt_hold = bus.count;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
    check("done_stop_ignored", {63'd0, bus.done}, 64'd1);
    check("done_count_stable", {32'd0, bus.count}, {32'd0, cnt_hold});

    // Saturation on the 4-bit instance, then re-launch clears count and overflow
    bus_s.start  = 1'b1;
    bus_s.window = 200;
    tick();
    bus_s.start = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 260 && !flag; i++) begin
      if (bus_s.done) flag = 1'b1;
      else tick();
    end
    check("sat_done_seen", {63'd0, flag}, 64'd1);
    check("sat_count", {60'd0, bus_s.count}, 64'd15);
    check("sat_overflow", {63'd0, bus_s.overflow}, 64'd1);
    bus_s.start  = 1'b1;
    bus_s.window = 16;
    tick();
    bus_s.start = 1'b0;
    check("relaunch_count_clr", {60'd0, bus_s.count}, 64'd0);
    check("relaunch_ovf_clr", {63'd0, bus_s.overflow}, 64'd0);
    flag = 1'b0;
    for (int i = 0; i < 60 && !flag; i++) begin
      if (bus_s.done) flag = 1'b1;
      else tick();
    end
    check("relaunch_done_seen", {63'd0, flag}, 64'd1);
    check("relaunch_count", {60'd0, bus_s.count}, 64'(pick(2, 4)));
    check("relaunch_overflow", {63'd0, bus_s.overflow}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
